outport_arbiter: RTL and testbench

- Round-robin, packet-locking (wormhole) arbiter for one router output port.
- Five input FIFOs compete for the port: bit order 0=L, 1=N, 2=E, 3=W, 4=S.
- Grants one requester at a time and holds the grant until that requester's tail flit has transferred.
- Gates per-requester ready with the downstream output-FIFO ready; drives the crossbar select and the output-FIFO write enable.

---
 rtl/outport_arbiter_if.sv | 44 ++++
 rtl/outport_arbiter.sv | 146 ++++++++++++++
 tb/tb_outport_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/outport_arbiter_if.sv
// ---------------------------------------------------------------------------
// outport_arbiter_if
//   Handshake bundle between one router output port's arbiter and its
//   surroundings (input FIFOs, crossbar, output FIFO).
//
//   Parameters : NREQ (requesters), CNTW (flit counter width)
//   Signals    :
//     req       - per-requester request (FIFO non-empty, routed here)
//     tail      - per-requester: head flit is a tail flit
//     out_ready - output FIFO can accept a flit this cycle
//     grant     - registered one-hot grant, zero when idle
//     grant_id  - registered binary index of the granted requester
//     busy      - registered, high while a packet holds the port
//     ready_out - pop qualifier back to the input FIFOs
//     fire      - output-FIFO write enable
//     flit_cnt  - flits transferred in the current packet
//   Modports   : master = arbiter side, slave = environment side
// ---------------------------------------------------------------------------
interface outport_arbiter_if #(
   parameter int unsigned NREQ = 5,
   parameter int unsigned CNTW = 8
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0] req;
   logic [NREQ-1:0] tail;
   logic            out_ready;
   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic            busy;
   logic [NREQ-1:0] ready_out;
   logic            fire;
   logic [CNTW-1:0] flit_cnt;

   modport master (
      input  req, tail, out_ready,
      output grant, grant_id, busy, ready_out, fire, flit_cnt
   );

   modport slave (
      output req, tail, out_ready,
      input  grant, grant_id, busy, ready_out, fire, flit_cnt
   );
endinterface

// File: rtl/outport_arbiter.sv
// ---------------------------------------------------------------------------
// outport_arbiter
//   Round-robin, packet-locking (wormhole) arbiter for one router output
//   port. Requester bit order: 0=L, 1=N, 2=E, 3=W, 4=S. A grant is held
//   until the granted requester's tail flit transfers; the rr pointer then
//   moves to the served requester so it has lowest priority next time.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - outport_arbiter_if.master (req/tail/out_ready in;
//            grant/grant_id/busy/ready_out/fire/flit_cnt out)
//   The interface instance must use the same NREQ/CNTW as this module.
//
//   Build option: OUTPORT_ARB_FAST_REARB_EN
//     Defined   - on a releasing tail fire, re-arbitrate in the same cycle
//                 (current owner masked out) so back-to-back packets from
//                 different requesters have no idle bubble.
//     Undefined - one idle cycle between packets.
// ---------------------------------------------------------------------------
module outport_arbiter #(
   parameter int unsigned NREQ = 5,
   parameter int unsigned CNTW = 8
) (
   input logic                clk,
   input logic                rst,
   outport_arbiter_if.master  bus
);
   localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]  gid_q,   gid_d;
   logic [IDW-1:0]  ptr_q,   ptr_d;
   logic [CNTW-1:0] cnt_q,   cnt_d;

   logic            fire_c;
   logic            rel;
   logic [IDW-1:0]  arb_base;
   logic [NREQ-1:0] arb_req;
   logic [IDW-1:0]  idx;
   logic            win_vld;
   logic [IDW-1:0]  win_id;
   logic [NREQ-1:0] win_oh;

   // Tail flit of the owning requester is transferring this cycle.
   assign rel = fire_c & bus.tail[gid_q];

   // Rotating-priority search: first set request starting at base+1.
   always_comb begin
      arb_base = ptr_q;
      arb_req  = bus.req;
`ifdef OUTPORT_ARB_FAST_REARB_EN
      // Same-cycle re-arbitration: pointer is effectively the releasing
      // owner, which is excluded so another waiter can take the port.
      if (rel) begin
         arb_base = gid_q;
         arb_req  = bus.req & ~grant_q;
      end
`endif
      win_vld = 1'b0;
      win_id  = '0;
      idx     = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         idx = IDW'((32'(arb_base) + k) % NREQ);
         if (!win_vld && arb_req[idx]) begin
            win_vld = 1'b1;
            win_id  = idx;
         end
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         ptr_q   <= IDW'(NREQ - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      win_oh  = '0;
      win_oh[win_id] = 1'b1;
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = LOCKED;
               grant_d = win_oh;
               gid_d   = win_id;
               cnt_d   = '0;
            end
         end
         LOCKED: begin
            if (rel) begin
               ptr_d   = gid_q;
               cnt_d   = '0;
               state_d = IDLE;
               grant_d = '0;
               gid_d   = '0;
`ifdef OUTPORT_ARB_FAST_REARB_EN
               if (win_vld) begin
                  state_d = LOCKED;
                  grant_d = win_oh;
                  gid_d   = win_id;
               end
`endif
            end else if (fire_c && (cnt_q != '1)) begin
               // Saturating count; sticks at all-ones on long packets.
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      fire_c        = (|(grant_q & bus.req)) & bus.out_ready;
      bus.fire      = fire_c;
      bus.ready_out = grant_q & {NREQ{bus.out_ready}};
      bus.grant     = grant_q;
      bus.grant_id  = gid_q;
      bus.busy      = (state_q == LOCKED);
      bus.flit_cnt  = cnt_q;
   end
endmodule

// File: tb/tb_outport_arbiter.sv
// ---------------------------------------------------------------------------
// tb_outport_arbiter
//   Directed bench for outport_arbiter. Two instances share the same
//   stimulus: dut_a with CNTW=8 and dut_b with CNTW=2 (counter saturation).
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   after inputs settle, and invariants are checked on the falling edge.
// ---------------------------------------------------------------------------
module tb_outport_arbiter;
   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] req;
   logic [4:0] tail;
   logic       out_ready;

   int vectors = 0;
   int errors  = 0;
   bit mon_en  = 1'b0;

   outport_arbiter_if #(.NREQ(5), .CNTW(8)) ifa ();
   outport_arbiter_if #(.NREQ(5), .CNTW(2)) ifb ();

   assign ifa.req = req;  assign ifa.tail = tail;  assign ifa.out_ready = out_ready;
   assign ifb.req = req;  assign ifb.tail = tail;  assign ifb.out_ready = out_ready;

   outport_arbiter #(.NREQ(5), .CNTW(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   outport_arbiter #(.NREQ(5), .CNTW(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

   always #5 clk = ~clk;

   // Structural invariants, every cycle once out of reset.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         vectors++;
         if (!$onehot0(ifa.grant)) begin errors++; $display("FAIL inv_onehot: grant=%b not one-hot/zero", ifa.grant); end
         vectors++;
         if (ifa.fire && !ifa.busy) begin errors++; $display("FAIL inv_fire_busy: fire=%b busy=%b, required busy=1", ifa.fire, ifa.busy); end
         vectors++;
         if ((ifa.ready_out & ~ifa.grant) !== 5'b0) begin errors++; $display("FAIL inv_ready_subset: ready_out=%b grant=%b", ifa.ready_out, ifa.grant); end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = '0; tail = '0; out_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      mon_en = 1'b1;
      #1;
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL rst_grant: got %b expected 00000", ifa.grant); end
      vectors++; if (ifa.grant_id !== 3'd0) begin errors++; $display("FAIL rst_gid: got %0d expected 0", ifa.grant_id); end
      vectors++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", ifa.busy); end
      vectors++; if (ifa.flit_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", ifa.flit_cnt); end
      vectors++; if (ifa.fire !== 1'b0) begin errors++; $display("FAIL rst_fire: got %b expected 0", ifa.fire); end
      step();
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL idle_noreq: got %b expected 00000", ifa.grant); end
   endtask

   task automatic test_single_packet();
      req = 5'b00001; out_ready = 1'b1; tail = '0;
      #1;
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL sp_pre_grant: got %b expected 00000", ifa.grant); end
      step();
      vectors++; if (ifa.grant !== 5'b00001) begin errors++; $display("FAIL sp_grant: got %b expected 00001", ifa.grant); end
      vectors++; if (ifa.grant_id !== 3'd0) begin errors++; $display("FAIL sp_gid: got %0d expected 0", ifa.grant_id); end
      vectors++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL sp_busy: got %b expected 1", ifa.busy); end
      vectors++; if (ifa.fire !== 1'b1) begin errors++; $display("FAIL sp_fire: got %b expected 1", ifa.fire); end
      vectors++; if (ifa.ready_out !== 5'b00001) begin errors++; $display("FAIL sp_ready: got %b expected 00001", ifa.ready_out); end
      step();
      vectors++; if (ifa.flit_cnt !== 8'd1) begin errors++; $display("FAIL sp_cnt1: got %0d expected 1", ifa.flit_cnt); end
      step();
      vectors++; if (ifa.flit_cnt !== 8'd2) begin errors++; $display("FAIL sp_cnt2: got %0d expected 2", ifa.flit_cnt); end
      tail = 5'b00001;
      step();
      req = '0; tail = '0;
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL sp_rel_grant: got %b expected 00000", ifa.grant); end
      vectors++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL sp_rel_busy: got %b expected 0", ifa.busy); end
      vectors++; if (ifa.flit_cnt !== 8'd0) begin errors++; $display("FAIL sp_rel_cnt: got %0d expected 0", ifa.flit_cnt); end
   endtask

   task automatic test_round_robin();
      logic [4:0] one;
      logic [4:0] exp_g;
      logic [2:0] exp_id;
      one = 5'b00001;
      pulse_rst();
      req = 5'b11111; out_ready = 1'b1; tail = '0;
      step();
      for (int p = 0; p < 6; p++) begin
         exp_id = 3'(p % 5);
         exp_g  = one << exp_id;
         vectors++; if (ifa.grant !== exp_g) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", p, ifa.grant, exp_g); end
         vectors++; if (ifa.grant_id !== exp_id) begin errors++; $display("FAIL rr_gid[%0d]: got %0d expected %0d", p, ifa.grant_id, exp_id); end
         vectors++; if (ifa.flit_cnt !== 8'd0) begin errors++; $display("FAIL rr_cnt0[%0d]: got %0d expected 0", p, ifa.flit_cnt); end
         tail = '0;
         step();
         vectors++; if (ifa.flit_cnt !== 8'd1) begin errors++; $display("FAIL rr_cnt1[%0d]: got %0d expected 1", p, ifa.flit_cnt); end
         tail = 5'b11111;
         step();
         tail = '0;
`ifndef OUTPORT_ARB_FAST_REARB_EN
         vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL rr_bubble[%0d]: got %b expected 00000", p, ifa.grant); end
         vectors++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rr_bubble_busy[%0d]: got %b expected 0", p, ifa.busy); end
         if (p < 5) step();
`endif
      end
      req = '0;
   endtask

   task automatic test_stall();
      pulse_rst();
      req = 5'b00100; out_ready = 1'b1; tail = '0;
      step();
      vectors++; if (ifa.grant !== 5'b00100) begin errors++; $display("FAIL st_grant: got %b expected 00100", ifa.grant); end
      vectors++; if (ifa.grant_id !== 3'd2) begin errors++; $display("FAIL st_gid: got %0d expected 2", ifa.grant_id); end
      step();
      req = 5'b00110; out_ready = 1'b0;
      #1;
      vectors++; if (ifa.fire !== 1'b0) begin errors++; $display("FAIL st_fire_off: got %b expected 0", ifa.fire); end
      vectors++; if (ifa.ready_out !== 5'b0) begin errors++; $display("FAIL st_ready_off: got %b expected 00000", ifa.ready_out); end
      step();
      vectors++; if (ifa.flit_cnt !== 8'd1) begin errors++; $display("FAIL st_cnt_hold: got %0d expected 1", ifa.flit_cnt); end
      vectors++; if (ifa.grant !== 5'b00100) begin errors++; $display("FAIL st_grant_hold: got %b expected 00100", ifa.grant); end
      out_ready = 1'b1; tail = 5'b00010;
      #1;
      vectors++; if (ifa.fire !== 1'b1) begin errors++; $display("FAIL st_fire_on: got %b expected 1", ifa.fire); end
      vectors++; if (ifa.ready_out !== 5'b00100) begin errors++; $display("FAIL st_ready_on: got %b expected 00100", ifa.ready_out); end
      step();
      vectors++; if (ifa.flit_cnt !== 8'd2) begin errors++; $display("FAIL st_cnt2: got %0d expected 2", ifa.flit_cnt); end
      vectors++; if (ifa.grant !== 5'b00100) begin errors++; $display("FAIL st_foreign_tail: got %b expected 00100", ifa.grant); end
      tail = 5'b00100; out_ready = 1'b0;
      step();
      vectors++; if (ifa.grant !== 5'b00100) begin errors++; $display("FAIL st_tail_nofire: got %b expected 00100", ifa.grant); end
      out_ready = 1'b1;
      step();
      req = 5'b00010; tail = '0;
`ifdef OUTPORT_ARB_FAST_REARB_EN
      vectors++; if (ifa.grant !== 5'b00010) begin errors++; $display("FAIL st_next_n: got %b expected 00010", ifa.grant); end
`else
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL st_release: got %b expected 00000", ifa.grant); end
      step();
      vectors++; if (ifa.grant !== 5'b00010) begin errors++; $display("FAIL st_next_n: got %b expected 00010", ifa.grant); end
`endif
      vectors++; if (ifa.grant_id !== 3'd1) begin errors++; $display("FAIL st_next_gid: got %0d expected 1", ifa.grant_id); end
      req = '0;
   endtask

   task automatic test_wormhole_hold();
      pulse_rst();
      req = 5'b01000; out_ready = 1'b1; tail = '0;
      step();
      vectors++; if (ifa.grant !== 5'b01000) begin errors++; $display("FAIL wh_grant: got %b expected 01000", ifa.grant); end
      step();
      req = 5'b10111;
      for (int c = 0; c < 4; c++) begin
         #1;
         vectors++; if (ifa.fire !== 1'b0) begin errors++; $display("FAIL wh_fire[%0d]: got %b expected 0", c, ifa.fire); end
         step();
         vectors++; if (ifa.grant !== 5'b01000) begin errors++; $display("FAIL wh_hold[%0d]: got %b expected 01000", c, ifa.grant); end
         vectors++; if (ifa.flit_cnt !== 8'd1) begin errors++; $display("FAIL wh_cnt[%0d]: got %0d expected 1", c, ifa.flit_cnt); end
      end
      req = 5'b11111; tail = 5'b01000;
      #1;
      vectors++; if (ifa.fire !== 1'b1) begin errors++; $display("FAIL wh_tail_fire: got %b expected 1", ifa.fire); end
      step();
      tail = '0;
`ifdef OUTPORT_ARB_FAST_REARB_EN
      vectors++; if (ifa.grant !== 5'b10000) begin errors++; $display("FAIL wh_release: got %b expected 10000", ifa.grant); end
`else
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL wh_release: got %b expected 00000", ifa.grant); end
`endif
      req = '0;
   endtask

   task automatic test_reset_mid_packet();
      pulse_rst();
      req = 5'b10000; out_ready = 1'b1; tail = '0;
      step();
      repeat (5) step();
      vectors++; if (ifa.flit_cnt !== 8'd5) begin errors++; $display("FAIL rm_cnt5: got %0d expected 5", ifa.flit_cnt); end
      vectors++; if (ifa.grant !== 5'b10000) begin errors++; $display("FAIL rm_grant_s: got %b expected 10000", ifa.grant); end
      rst = 1'b1; req = 5'b11111;
      step();
      rst = 1'b0;
      vectors++; if (ifa.grant !== 5'b0) begin errors++; $display("FAIL rm_grant0: got %b expected 00000", ifa.grant); end
      vectors++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rm_busy0: got %b expected 0", ifa.busy); end
      vectors++; if (ifa.flit_cnt !== 8'd0) begin errors++; $display("FAIL rm_cnt0: got %0d expected 0", ifa.flit_cnt); end
      step();
      vectors++; if (ifa.grant !== 5'b00001) begin errors++; $display("FAIL rm_next_l: got %b expected 00001", ifa.grant); end
      req = '0;
   endtask

   task automatic test_cnt_saturation();
      logic [1:0] exp_b [5];
      exp_b = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      pulse_rst();
      req = 5'b00001; out_ready = 1'b1; tail = '0;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         vectors++; if (ifb.flit_cnt !== exp_b[i]) begin errors++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", i, ifb.flit_cnt, exp_b[i]); end
         vectors++; if (ifa.flit_cnt !== 8'(i + 1)) begin errors++; $display("FAIL sat_cnt8[%0d]: got %0d expected %0d", i, ifa.flit_cnt, i + 1); end
      end
      tail = 5'b00001;
      step();
      tail = '0; req = '0;
      vectors++; if (ifb.flit_cnt !== 2'd0) begin errors++; $display("FAIL sat_release: got %0d expected 0", ifb.flit_cnt); end
      vectors++; if (ifb.grant !== 5'b0) begin errors++; $display("FAIL sat_release_grant: got %b expected 00000", ifb.grant); end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_wormhole_hold();
      test_reset_mid_packet();
      test_cnt_saturation();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
